// File: rtl/times_table_sweeper.sv
// times_table_sweeper: walks every 3-bit operand pair through times_table and streams each
// registered product downstream with a running row sum over a valid/ready handshake.
module times_table_sweeper #(
    parameter logic [2:0] LAST_A = 3'd7,
    parameter logic [2:0] LAST_B = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] mul_a,
    output logic [2:0] mul_b,
    output logic       mul_en,
    input  logic [5:0] mul_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_a,
    output logic [2:0] out_b,
    output logic [5:0] out_product,
    output logic [7:0] row_sum,
    output logic       row_end,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    logic [2:0] state;
    logic [7:0] acc;
    logic [7:0] sum;
    logic       last_a;
    logic       last_b;
    assign sum    = acc + {2'b00, mul_result};
    assign last_a = mul_a == LAST_A;
    assign last_b = mul_b == LAST_B;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_en      <= 1'b0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_product <= '0;
            row_sum     <= '0;
            row_end     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        mul_a  <= '0;
                        mul_b  <= '0;
                        mul_en <= 1'b1;
                        acc    <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_en <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    out_a       <= mul_a;
                    out_b       <= mul_b;
                    out_product <= mul_result;
                    row_sum     <= sum;
                    acc         <= sum;
                    row_end     <= last_a;
                    out_valid   <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_a && last_b) begin
                            state <= DONE;
                        end else begin
                            if (last_a) begin
                                mul_a <= '0;
                                mul_b <= mul_b + 3'd1;
                                acc   <= '0;
                            end else begin
                                mul_a <= mul_a + 3'd1;
                            end
                            mul_en <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
